// File: rtl/led_pattern_pkg.sv
// Shared types for the LED pattern generator: pattern select and bounce direction.
package led_pattern_pkg;

   typedef enum logic [1:0] {
      ROT_L  = 2'd0,
      ROT_R  = 2'd1,
      BOUNCE = 2'd2,
      COUNT  = 2'd3
   } led_mode_t;

   typedef enum logic {
      UP   = 1'b0,
      DOWN = 1'b1
   } dir_t;

endpackage

// File: rtl/led_pattern_gen_prescaler.sv
// Wrap counter that paces pattern steps: one step strobe every DIV enabled cycles.
module led_prescaler #(
   parameter int DIV = 12000000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   output logic step
);

   localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (en)
         cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
   end

   // Gated by rst_n so the strobe is low during reset even when DIV = 1.
   assign step = rst_n && en && (cnt == LAST);

endmodule

// File: rtl/led_pattern_gen.sv
// WIDTH-bit LED bank driver: rotate left/right, bounce or binary count, one
// update per prescaler step; a mode change first reloads the pattern.
module led_pattern_gen
   import led_pattern_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int DIV   = 12000000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [1:0]       mode,
   output logic [WIDTH-1:0] leds,
   output logic             step,
   output logic             alive
);

   led_mode_t        mode_q;
   led_mode_t        mode_in;
   dir_t             dir_q;
   dir_t             dir_d;
   logic [WIDTH-1:0] leds_d;

   assign mode_in = led_mode_t'(mode);
   assign alive   = 1'b1;

   led_prescaler #(.DIV(DIV)) u_prescaler (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (en),
      .step (step)
   );

   always_comb begin
      leds_d = leds;
      dir_d  = dir_q;
      if (mode_in != mode_q) begin
         // Reload step: restart the new pattern from a known position.
         leds_d = WIDTH'(1);
         dir_d  = UP;
      end else begin
         case (mode_q)
            ROT_L:  leds_d = {leds[WIDTH-2:0], leds[WIDTH-1]};
            ROT_R:  leds_d = {leds[0], leds[WIDTH-1:1]};
            BOUNCE: begin
               if (dir_q == UP) begin
                  if (leds[WIDTH-1]) begin
                     dir_d  = DOWN;
                     leds_d = leds >> 1;
                  end else begin
                     leds_d = leds << 1;
                  end
               end else begin
                  if (leds[0]) begin
                     dir_d  = UP;
                     leds_d = leds << 1;
                  end else begin
                     leds_d = leds >> 1;
                  end
               end
            end
            COUNT:  leds_d = leds + 1'b1;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         leds   <= WIDTH'(1);
         dir_q  <= UP;
         mode_q <= ROT_L;
      end else if (step) begin
         leds   <= leds_d;
         dir_q  <= dir_d;
         mode_q <= mode_in;
      end
   end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Bench for led_pattern_gen: four configurations, directed scenarios plus a
// randomized run checked against an arithmetic reference model.
module tb_led_pattern_gen;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [3:0]      en_v = '0;
   logic [3:0][1:0] mode_v = '0;
   logic [3:0]      step_v;
   logic [3:0]      alive_v;
   logic [3:0]      leds_a, leds_b, leds_d;
   logic [2:0]      leds_c;

   int total = 0;
   int bad   = 0;

   int W[4] = '{4, 4, 3, 4};
   int D[4] = '{3, 1, 1, 4};

   int m_leds[4];
   int m_cnt[4];
   int m_dir[4];
   int m_mode[4];

   always #5 clk = ~clk;

   led_pattern_gen #(.WIDTH(4), .DIV(3)) u_a (.clk(clk), .rst_n(rst_n), .en(en_v[0]), .mode(mode_v[0]),
      .leds(leds_a), .step(step_v[0]), .alive(alive_v[0]));
   led_pattern_gen #(.WIDTH(4), .DIV(1)) u_b (.clk(clk), .rst_n(rst_n), .en(en_v[1]), .mode(mode_v[1]),
      .leds(leds_b), .step(step_v[1]), .alive(alive_v[1]));
   led_pattern_gen #(.WIDTH(3), .DIV(1)) u_c (.clk(clk), .rst_n(rst_n), .en(en_v[2]), .mode(mode_v[2]),
      .leds(leds_c), .step(step_v[2]), .alive(alive_v[2]));
   led_pattern_gen #(.WIDTH(4), .DIV(4)) u_d (.clk(clk), .rst_n(rst_n), .en(en_v[3]), .mode(mode_v[3]),
      .leds(leds_d), .step(step_v[3]), .alive(alive_v[3]));

   // Reference model: patterns as integers, shifts as multiply/divide.
   function automatic int next_leds(int w, int md, int ap, int l, int d);
      int top  = 1 << (w - 1);
      int full = 1 << w;
      if (md != ap) return 1;
      case (md)
         0: return (l * 2) % full + l / top;
         1: return l / 2 + (l % 2) * top;
         2: begin
            if (d == 0) return ((l / top) % 2 == 1) ? l / 2 : (l * 2) % full;
            else        return (l % 2 == 1) ? (l * 2) % full : l / 2;
         end
         default: return (l + 1) % full;
      endcase
   endfunction

   function automatic int next_dir(int w, int md, int ap, int l, int d);
      int top = 1 << (w - 1);
      if (md != ap) return 0;
      if (md != 2) return d;
      if (d == 0) return ((l / top) % 2 == 1) ? 1 : 0;
      return (l % 2 == 1) ? 0 : 1;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) begin
            m_leds[i] <= 1;
            m_cnt[i]  <= 0;
            m_dir[i]  <= 0;
            m_mode[i] <= 0;
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (en_v[i]) begin
               if (m_cnt[i] == D[i] - 1) begin
                  m_cnt[i]  <= 0;
                  m_leds[i] <= next_leds(W[i], int'(mode_v[i]), m_mode[i], m_leds[i], m_dir[i]);
                  m_dir[i]  <= next_dir(W[i], int'(mode_v[i]), m_mode[i], m_leds[i], m_dir[i]);
                  m_mode[i] <= int'(mode_v[i]);
               end else begin
                  m_cnt[i] <= m_cnt[i] + 1;
               end
            end
         end
      end
   end

   function automatic logic [3:0] dut_leds(int i);
      case (i)
         0:       return leds_a;
         1:       return leds_b;
         2:       return {1'b0, leds_c};
         default: return leds_d;
      endcase
   endfunction

   task automatic do_reset();
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n  = 1'b0;
      en_v   = '0;
      mode_v = '0;
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         total++;
         if (dut_leds(i) !== 4'd1) begin
            bad++; $display("FAIL reset_leds[%0d] got %b want 0001", i, dut_leds(i));
         end
         total++;
         if (step_v[i] !== 1'b0) begin
            bad++; $display("FAIL reset_step[%0d] got %b want 0", i, step_v[i]);
         end
         total++;
         if (alive_v[i] !== 1'b1) begin
            bad++; $display("FAIL reset_alive[%0d] got %b want 1", i, alive_v[i]);
         end
      end
   endtask

   task automatic test_rot_l();
      logic [3:0] exp;
      en_v   = 4'b0001;
      mode_v = '0;
      do_reset();
      for (int e = 1; e <= 12; e++) begin
         @(negedge clk);
         exp = 4'(1 << ((e / 3) % 4));
         total++;
         if (leds_a !== exp) begin
            bad++; $display("FAIL rot_l_leds edge %0d got %b want %b", e, leds_a, exp);
         end
         total++;
         if (step_v[0] !== (e % 3 == 2)) begin
            bad++; $display("FAIL rot_l_step edge %0d got %b want %b", e, step_v[0], (e % 3 == 2));
         end
      end
   endtask

   task automatic test_bounce();
      logic [3:0] bt[8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
      en_v      = 4'b0010;
      mode_v    = '0;
      mode_v[1] = 2'd2;
      do_reset();
      for (int e = 0; e < 8; e++) begin
         @(negedge clk);
         total++;
         if (leds_b !== bt[e]) begin
            bad++; $display("FAIL bounce_leds step %0d got %b want %b", e, leds_b, bt[e]);
         end
         total++;
         if (step_v[1] !== 1'b1) begin
            bad++; $display("FAIL bounce_step step %0d got %b want 1", e, step_v[1]);
         end
      end
   endtask

   task automatic test_count_wrap();
      logic [2:0] exp;
      en_v      = 4'b0100;
      mode_v    = '0;
      mode_v[2] = 2'd3;
      do_reset();
      for (int e = 1; e <= 9; e++) begin
         @(negedge clk);
         exp = 3'(e % 8);
         total++;
         if (leds_c !== exp) begin
            bad++; $display("FAIL count_leds edge %0d got %b want %b", e, leds_c, exp);
         end
         total++;
         if (step_v[2] !== 1'b1) begin
            bad++; $display("FAIL count_step edge %0d got %b want 1", e, step_v[2]);
         end
      end
   endtask

   task automatic test_en_freeze();
      en_v   = 4'b1000;
      mode_v = '0;
      do_reset();
      repeat (2) @(negedge clk);
      en_v[3] = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         total++;
         if (leds_d !== 4'b0001 || step_v[3] !== 1'b0) begin
            bad++; $display("FAIL freeze_hold cycle %0d got leds=%b step=%b want 0001/0", c, leds_d, step_v[3]);
         end
      end
      en_v[3] = 1'b1;
      @(negedge clk);
      total++;
      if (leds_d !== 4'b0001 || step_v[3] !== 1'b1) begin
         bad++; $display("FAIL freeze_resume1 got leds=%b step=%b want 0001/1", leds_d, step_v[3]);
      end
      @(negedge clk);
      total++;
      if (leds_d !== 4'b0010 || step_v[3] !== 1'b0) begin
         bad++; $display("FAIL freeze_resume2 got leds=%b step=%b want 0010/0", leds_d, step_v[3]);
      end
   endtask

   task automatic test_mode_change();
      en_v      = 4'b1000;
      mode_v    = '0;
      mode_v[3] = 2'd1;
      do_reset();
      repeat (12) @(negedge clk);
      total++;
      if (leds_d !== 4'b0100) begin
         bad++; $display("FAIL modechg_pre got %b want 0100", leds_d);
      end
      @(negedge clk);
      mode_v[3] = 2'd0;
      repeat (3) @(negedge clk);
      total++;
      if (leds_d !== 4'b0001) begin
         bad++; $display("FAIL modechg_reload got %b want 0001", leds_d);
      end
      repeat (4) @(negedge clk);
      total++;
      if (leds_d !== 4'b0010) begin
         bad++; $display("FAIL modechg_after got %b want 0010", leds_d);
      end
   endtask

   task automatic test_async_reset();
      en_v      = 4'b0010;
      mode_v    = '0;
      mode_v[1] = 2'd2;
      do_reset();
      repeat (5) @(negedge clk);
      total++;
      if (leds_b !== 4'b0100) begin
         bad++; $display("FAIL async_pre got %b want 0100", leds_b);
      end
      #2 rst_n = 1'b0;
      #1;
      total++;
      if (leds_b !== 4'b0001 || step_v[1] !== 1'b0) begin
         bad++; $display("FAIL async_now got leds=%b step=%b want 0001/0", leds_b, step_v[1]);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      total++;
      if (leds_b !== 4'b0001) begin
         bad++; $display("FAIL async_load got %b want 0001", leds_b);
      end
      @(negedge clk);
      total++;
      if (leds_b !== 4'b0010) begin
         bad++; $display("FAIL async_first_shift got %b want 0010", leds_b);
      end
   endtask

   task automatic test_random();
      logic exp_step;
      for (int i = 0; i < 4; i++) mode_v[i] = 2'($urandom_range(3));
      en_v = 4'($urandom);
      do_reset();
      for (int n = 0; n < 600; n++) begin
         @(negedge clk);
         for (int i = 0; i < 4; i++) begin
            exp_step = rst_n && en_v[i] && (m_cnt[i] == D[i] - 1);
            total++;
            if (dut_leds(i) !== 4'(m_leds[i])) begin
               bad++; $display("FAIL rand_leds[%0d] cycle %0d got %b want %b", i, n, dut_leds(i), 4'(m_leds[i]));
            end
            total++;
            if (step_v[i] !== exp_step) begin
               bad++; $display("FAIL rand_step[%0d] cycle %0d got %b want %b", i, n, step_v[i], exp_step);
            end
         end
         total++;
         if (alive_v !== 4'hf) begin
            bad++; $display("FAIL rand_alive cycle %0d got %b want 1111", n, alive_v);
         end
         for (int i = 0; i < 4; i++) begin
            en_v[i] = ($urandom_range(3) != 0);
            if ($urandom_range(9) == 0) mode_v[i] = 2'($urandom_range(3));
         end
      end
   endtask

   initial begin
      test_reset();
      test_rot_l();
      test_bounce();
      test_count_wrap();
      test_en_freeze();
      test_mode_change();
      test_async_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
